// File: rtl/xr_fault_event_logger.sv
// Fault event logger: turns governor fault status into a timestamped FWFT event FIFO
// with a valid/ready drain port, level interrupt and saturating overflow drop counter.
module xr_fault_event_logger #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fault_alarm,
  input  logic [3:0]                 fault_code,
  input  logic [3:0]                 fault_source,
  input  logic [2:0]                 system_state,
  input  logic                       irq_enable,
  input  logic                       clr_overflow,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [TS_W+10:0]           rd_data,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  output logic                       irq_event
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = TS_W + 11;

  logic [TS_W-1:0] ts;
  logic            prev_alarm;
  logic [3:0]      prev_code, prev_source;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [DW-1:0]   mem [DEPTH];

  logic evt, full, empty, pop, push, drop;
  logic [7:0] drop_base;

  assign evt   = fault_alarm & (~prev_alarm | (fault_code != prev_code) |
                                (fault_source != prev_source));
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & rd_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push  = evt & (~full | pop);
  assign drop  = evt & full & ~pop;

  assign rd_valid   = ~empty;
  assign fifo_count = wr_ptr - rd_ptr;
  assign irq_event  = irq_enable & rd_valid;
  // gate with rd_valid so never-written storage cannot leak X onto the bus
  assign rd_data    = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // clear only affects the old value; a coincident drop still counts
  assign drop_base  = clr_overflow ? 8'd0 : drop_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts          <= '0;
      prev_alarm  <= 1'b0;
      prev_code   <= '0;
      prev_source <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      ts          <= ts + 1'b1;
      prev_alarm  <= fault_alarm;
      prev_code   <= fault_code;
      prev_source <= fault_source;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      overflow    <= drop | (overflow & ~clr_overflow);
      if (drop)
        drop_count <= (drop_base == 8'hFF) ? 8'hFF : drop_base + 8'd1;
      else
        drop_count <= drop_base;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {ts, system_state, fault_source, fault_code};
  end

endmodule

// File: tb/tb_xr_fault_event_logger.sv
// Directed bench for xr_fault_event_logger: latency, event filtering, overflow,
// full push+pop, drop saturation and async reset.
module tb_xr_fault_event_logger;
  localparam int DEPTH = 16;
  localparam int TS_W  = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fault_alarm, irq_enable, clr_overflow, rd_ready;
  logic [3:0]  fault_code, fault_source;
  logic [2:0]  system_state;
  logic        rd_valid, overflow, irq_event;
  logic [TS_W+10:0] rd_data;
  logic [4:0]  fifo_count;
  logic [7:0]  drop_count;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [TS_W+10:0] first_e, last_e;

  xr_fault_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .fault_alarm(fault_alarm), .fault_code(fault_code),
    .fault_source(fault_source), .system_state(system_state), .irq_enable(irq_enable),
    .clr_overflow(clr_overflow), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .fifo_count(fifo_count), .overflow(overflow),
    .drop_count(drop_count), .irq_event(irq_event)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // advance one clock; inputs applied and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [TS_W+10:0] ent(input int t, input logic [2:0] s,
                                           input logic [3:0] src, input logic [3:0] c);
    return {t[TS_W-1:0], s, src, c};
  endfunction

  initial begin
    rst_n = 1'b0; fault_alarm = 1'b0; fault_code = '0; fault_source = '0;
    system_state = '0; irq_enable = 1'b1; clr_overflow = 1'b0; rd_ready = 1'b0;
    #12 rst_n = 1'b1;
    cyc = 0;
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_irq", irq_event, 0);

    // first event at ts=10
    repeat (10) tick();
    fault_alarm = 1'b1; fault_code = 4'h3; fault_source = 4'd7; system_state = 3'd2;
    tick();
    chk("t1_valid", rd_valid, 1);
    chk("t1_data", rd_data, {32'd10, 3'd2, 4'd7, 4'h3});
    chk("t1_count", fifo_count, 1);
    chk("t1_irq", irq_event, 1);
    irq_enable = 1'b0;
    #1 chk("t1_irq_gated", irq_event, 0);
    irq_enable = 1'b1;

    // held code, state-only change, then code change at ts=16
    tick(); tick();
    system_state = 3'd3;
    tick(); tick(); tick();
    fault_code = 4'h5;
    tick();
    chk("t2_count", fifo_count, 2);
    fault_alarm = 1'b0;
    tick(); tick();
    chk("t2_fall", fifo_count, 2);
    rd_ready = 1'b1;
    tick();
    chk("t2_second", rd_data, {32'd16, 3'd3, 4'd7, 4'h5});
    chk("t2_pop_count", fifo_count, 1);
    tick();
    chk("t2_empty", rd_valid, 0);
    chk("t2_irq_off", irq_event, 0);
    rd_ready = 1'b0;

    // 20 back-to-back events into a 16-entry FIFO
    system_state = 3'd4;
    for (int i = 0; i < 20; i++) begin
      fault_alarm = 1'b1; fault_code = i[3:0]; fault_source = 4'(i % 12);
      if (i == 0) first_e = ent(cyc, 3'd4, 4'd0, 4'd0);
      tick();
    end
    fault_alarm = 1'b0;
    chk("t3_count", fifo_count, 16);
    chk("t3_ovf", overflow, 1);
    chk("t3_drop", drop_count, 4);
    chk("t3_oldest", rd_data, first_e);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("t3_clr_ovf", overflow, 0);
    chk("t3_clr_drop", drop_count, 0);
    chk("t3_clr_count", fifo_count, 16);

    // full FIFO: push and pop together
    fault_alarm = 1'b1; fault_code = 4'h9; fault_source = 4'd11; system_state = 3'd5;
    rd_ready = 1'b1;
    last_e = ent(cyc, 3'd5, 4'd11, 4'h9);
    tick();
    fault_alarm = 1'b0;
    chk("t4_count", fifo_count, 16);
    chk("t4_drop", drop_count, 0);
    chk("t4_ovf", overflow, 0);
    repeat (15) tick();
    chk("t4_last", rd_data, last_e);
    chk("t4_last_count", fifo_count, 1);
    tick();
    chk("t4_drained", fifo_count, 0);
    rd_ready = 1'b0;

    // 16 stored + 300 dropped -> saturate
    for (int i = 0; i < 316; i++) begin
      fault_alarm = 1'b1; fault_code = i[3:0];
      tick();
    end
    chk("t5_sat", drop_count, 255);
    chk("t5_ovf", overflow, 1);
    chk("t5_count", fifo_count, 16);
    fault_code = 4'hE; clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("t5_clr_drop", drop_count, 1);
    chk("t5_clr_ovf", overflow, 1);

    // drain to 5, then async reset with alarm high
    fault_alarm = 1'b0; rd_ready = 1'b1;
    repeat (11) tick();
    rd_ready = 1'b0;
    chk("t6_five", fifo_count, 5);
    fault_alarm = 1'b1; fault_code = 4'h2; fault_source = 4'd4; system_state = 3'd1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", rd_valid, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_drop", drop_count, 0);
    chk("t6_rst_irq", irq_event, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    tick();
    chk("t6_new_count", fifo_count, 1);
    chk("t6_new_data", rd_data, {32'd0, 3'd1, 4'd4, 4'h2});
    tick();
    chk("t6_no_repeat", fifo_count, 1);

    $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/xr_fault_event_logger.md
# xr_fault_event_logger

Downstream of the XR core's XENOS boundary governor: watches the governor's fault status (alarm, code, source channel, system state) and records each distinct fault event, with a free-running timestamp, into a first-word-fall-through FIFO. Host or firmware drains the FIFO through a valid/ready read port. The block raises a level interrupt while unread events exist and counts events dropped on overflow. It turns the governor's instantaneous fault outputs into a lossless, ordered event history.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- TS_W, 32, timestamp width
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- fault_alarm  in  1  governor fault flag (level)
- fault_code  in  4  governor fault code
- fault_source  in  4  faulting channel index 0..11
- system_state  in  3  governor state
- irq_enable  in  1  gates irq_event
- clr_overflow  in  1  one-cycle pulse: clears overflow and drop_count
- rd_valid  out  1  head entry available
- rd_ready  in  1  consumer accepts head
- rd_data  out  TS_W+11  {timestamp, system_state, fault_source, fault_code}, MSB→LSB
- fifo_count  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- overflow  out  1  sticky: at least one event dropped
- drop_count  out  8  dropped events, saturates at 255
- irq_event  out  1  irq_enable & rd_valid

## Operation
- Timestamp counter ts: TS_W bits, resets to 0, +1 every cycle, wraps to 0 after all-ones.
- Registers prev_alarm, prev_code, prev_source hold the previous cycle's inputs; reset to 0.
- Event condition, evaluated each cycle on current inputs: fault_alarm & (~prev_alarm | fault_code≠prev_code | fault_source≠prev_source). Deassertion of fault_alarm is not an event; system_state changes alone are not events.
- Push on event: entry = {ts, system_state, fault_source, fault_code}, with ts the counter value in the detecting cycle.
- Pop when rd_valid & rd_ready; rd_data shows head combinationally from storage (FWFT); undefined content when rd_valid=0 but must not be X-propagating garbage from reset (storage need not be reset).
- Circular buffer: wr_ptr, rd_ptr with extra wrap bit; full = pointers equal except MSB; empty = equal.
- Push & pop same cycle: both take effect; allowed when full (pop frees the slot) — no drop, count unchanged.
- Push when full without pop: entry discarded, overflow←1, drop_count←min(drop_count+1,255).
- Push when empty with rd_ready=1: rd_valid was 0, so no pop; entry stored.
- clr_overflow in the same cycle as a drop: clear wins only for the old value; result overflow=1, drop_count=1.
- No state machine beyond FIFO; all outputs derive from registered state except irq_event and rd_data (combinational from registers).

## Timing
- Reset values: rd_valid=0, fifo_count=0, overflow=0, drop_count=0, irq_event=0, ts=0, pointers=0.
- Latency: event on inputs in cycle N → written at edge ending N → rd_valid=1, fifo_count updated in cycle N+1.
- Pop at edge ending cycle M → next entry (or rd_valid=0) in cycle M+1; sustained 1 pop/cycle.
- Sustained 1 push/cycle supported (e.g. fault_code changing every cycle with fault_alarm held).
- Async reset mid-operation: all contents discarded immediately; prev_* cleared, so a still-high fault_alarm after release logs a new event in the first clocked cycle.

## Test plan
- Reset, then fault_alarm 0→1 with code=4'h3, source=4'd7, state=3'd2 at ts=10 → cycle later rd_valid=1, rd_data={32'd10,3'd2,4'd7,4'h3}, fifo_count=1, irq_event=1 with irq_enable=1.
- Hold fault_alarm high, code constant 5 cycles, then code→4'h5 → exactly 2 entries total; second timestamp = first + 6; alarm falling logs nothing.
- DEPTH=16, rd_ready=0, 20 distinct events → fifo_count=16, overflow=1, drop_count=4; first entry still oldest; clr_overflow → both 0.
- Full FIFO, event and rd_ready=1 in same cycle → fifo_count stays 16, drop_count unchanged, new entry appears last after 15 further pops.
- 300 drops with no clr → drop_count=255; clr_overflow coincident with a drop → drop_count=1, overflow=1.
- Assert rst_n=0 with 5 entries queued and fault_alarm high → outputs at reset values asynchronously; after release, one new event logged with timestamp 0.
